// File: rtl/obstacle_follower.sv
// Scrolling obstacle that drifts horizontally and latches a hit on player overlap.
// Define FOLLOWER_RESPAWN_EN to reload obs_x at X_INIT whenever obs_y wraps to 0.
module obstacle_follower #(
  parameter int Y_INIT  = 0,
  parameter int X_INIT  = 0,
  parameter int CAR_DIV = 50000,
  parameter int DIR     = 0,
  parameter int OBS_W   = 32,
  parameter int OBS_H   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_followers,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [9:0] obs_x,
  output logic [9:0] obs_y,
  output logic       hit,
  output logic       active
);

  localparam int CNT_W = $clog2(CAR_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CAR_DIV - 1);
  localparam logic [9:0] X0 = 10'(X_INIT);
  localparam logic [9:0] Y0 = 10'(Y_INIT);

  typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;

  state_t           state_q, state_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, active_q;

  logic [10:0] px11, py11, ox11, oy11;
  logic        collide;
  logic        y_wrap;
  logic [9:0]  y_next;
  logic [9:0]  x_next;
  logic        y_apply;

  assign px11 = {1'b0, player_x};
  assign py11 = {1'b0, player_y};
  assign ox11 = {1'b0, x_q};
  assign oy11 = {1'b0, y_q};

  assign collide = (px11 < ox11 + 11'(OBS_W)) && (ox11 < px11 + 11'd16) &&
                   (py11 < oy11 + 11'(OBS_H)) && (oy11 < py11 + 11'd16);

  assign y_wrap = (oy11 + 11'd2) >= 11'd480;
  assign y_next = y_wrap ? 10'd0 : y_q + 10'd2;

  always_comb begin
    if (DIR == 0) x_next = (x_q == 10'd639) ? 10'd0 : x_q + 10'd1;
    else          x_next = (x_q == 10'd0) ? 10'd639 : x_q - 10'd1;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    y_apply = 1'b0;
    case (state_q)
      IDLE: begin
        if (move_followers) begin
          state_d = RUN;
          cnt_d   = '0;
          y_apply = 1'b1;
        end
      end
      RUN: begin
        // A collision freezes everything on the edge that enters HIT.
        if (collide) begin
          state_d = HIT;
        end else begin
          if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            x_d   = x_next;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          y_apply = move_followers;
        end
      end
      default: ;
    endcase
    if (y_apply) y_d = y_next;
`ifdef FOLLOWER_RESPAWN_EN
    if (y_apply && y_wrap) begin
      x_d   = X0;
      cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= X0;
      y_q      <= Y0;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      hit_q    <= (state_d == HIT);
      active_q <= (state_d == RUN);
    end
  end

  assign obs_x  = x_q;
  assign obs_y  = y_q;
  assign hit    = hit_q;
  assign active = active_q;

endmodule

// File: tb/tb_obstacle_follower.sv
// Self-checking bench: four differently-parameterised obstacles plus a randomized run against a model.
module tb_obstacle_follower;

  localparam int U2_X = 638;
  localparam int U2_Y = 440;
  localparam int U2_DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst0, mf0, hit0, act0;
  logic [9:0] px0, py0, ox0, oy0;
  logic       rst1, mf1, hit1, act1;
  logic [9:0] px1, py1, ox1, oy1;
  logic       rst2, mf2, hit2, act2;
  logic [9:0] px2, py2, ox2, oy2;
  logic       rst3, mf3, hit3, act3;
  logic [9:0] px3, py3, ox3, oy3;

  obstacle_follower #(.Y_INIT(100), .X_INIT(200), .CAR_DIV(20), .DIR(0)) u0 (
    .clk(clk), .reset(rst0), .move_followers(mf0), .player_x(px0), .player_y(py0),
    .obs_x(ox0), .obs_y(oy0), .hit(hit0), .active(act0));
  obstacle_follower #(.Y_INIT(478), .X_INIT(300), .CAR_DIV(20), .DIR(0)) u1 (
    .clk(clk), .reset(rst1), .move_followers(mf1), .player_x(px1), .player_y(py1),
    .obs_x(ox1), .obs_y(oy1), .hit(hit1), .active(act1));
  obstacle_follower #(.Y_INIT(U2_Y), .X_INIT(U2_X), .CAR_DIV(U2_DIV), .DIR(0)) u2 (
    .clk(clk), .reset(rst2), .move_followers(mf2), .player_x(px2), .player_y(py2),
    .obs_x(ox2), .obs_y(oy2), .hit(hit2), .active(act2));
  obstacle_follower #(.Y_INIT(0), .X_INIT(1), .CAR_DIV(4), .DIR(1)) u3 (
    .clk(clk), .reset(rst3), .move_followers(mf3), .player_x(px3), .player_y(py3),
    .obs_x(ox3), .obs_y(oy3), .hit(hit3), .active(act3));

  task automatic test_reset;
    @(posedge clk);
    #1;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    #1;
    checks++; if (ox0 !== 10'd200) begin errors++; $display("FAIL reset_x0 got %0d exp 200", ox0); end
    checks++; if (oy0 !== 10'd100) begin errors++; $display("FAIL reset_y0 got %0d exp 100", oy0); end
    checks++; if (hit0 !== 1'b0) begin errors++; $display("FAIL reset_hit0 got %b exp 0", hit0); end
    checks++; if (act0 !== 1'b0) begin errors++; $display("FAIL reset_act0 got %b exp 0", act0); end
    checks++; if (oy1 !== 10'd478) begin errors++; $display("FAIL reset_y1 got %0d exp 478", oy1); end
    checks++; if (ox2 !== 10'd638) begin errors++; $display("FAIL reset_x2 got %0d exp 638", ox2); end
    checks++; if (ox3 !== 10'd1) begin errors++; $display("FAIL reset_x3 got %0d exp 1", ox3); end
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    $display("reset: checked initial state of all instances");
  endtask

  task automatic test_scroll;
    mf0 = 1'b1;
    @(negedge clk);
    checks++; if (act0 !== 1'b1) begin errors++; $display("FAIL scroll_active got %b exp 1", act0); end
    checks++; if (oy0 !== 10'd102) begin errors++; $display("FAIL scroll_y1 got %0d exp 102", oy0); end
    repeat (2) @(negedge clk);
    mf0 = 1'b0;
    checks++; if (oy0 !== 10'd106) begin errors++; $display("FAIL scroll_y3 got %0d exp 106", oy0); end
    checks++; if (ox0 !== 10'd200) begin errors++; $display("FAIL scroll_x_early got %0d exp 200", ox0); end
    repeat (17) @(negedge clk);
    checks++; if (ox0 !== 10'd200) begin errors++; $display("FAIL scroll_x_19 got %0d exp 200", ox0); end
    @(negedge clk);
    checks++; if (ox0 !== 10'd201) begin errors++; $display("FAIL scroll_x_20 got %0d exp 201", ox0); end
    $display("scroll: y=%0d x=%0d", oy0, ox0);
  endtask

  task automatic test_collision;
    px0 = 10'd233; py0 = 10'd106;
    @(negedge clk);
    checks++; if (hit0 !== 1'b0) begin errors++; $display("FAIL nohit_edge got %b exp 0", hit0); end
    checks++; if (act0 !== 1'b1) begin errors++; $display("FAIL nohit_active got %b exp 1", act0); end
    px0 = 10'd232;
    @(negedge clk);
    checks++; if (hit0 !== 1'b1) begin errors++; $display("FAIL hit_edge got %b exp 1", hit0); end
    checks++; if (act0 !== 1'b0) begin errors++; $display("FAIL hit_active got %b exp 0", act0); end
    mf0 = 1'b1;
    repeat (3) @(negedge clk);
    mf0 = 1'b0;
    repeat (25) @(negedge clk);
    checks++; if (ox0 !== 10'd201) begin errors++; $display("FAIL hit_freeze_x got %0d exp 201", ox0); end
    checks++; if (oy0 !== 10'd106) begin errors++; $display("FAIL hit_freeze_y got %0d exp 106", oy0); end
    checks++; if (hit0 !== 1'b1) begin errors++; $display("FAIL hit_hold got %b exp 1", hit0); end
    $display("collision: hit=%b x=%0d y=%0d", hit0, ox0, oy0);
  endtask

  task automatic test_reset_mid_hit;
    @(posedge clk);
    #2 rst0 = 1'b1;
    #1;
    checks++; if (hit0 !== 1'b0) begin errors++; $display("FAIL rsthit_hit got %b exp 0", hit0); end
    checks++; if (act0 !== 1'b0) begin errors++; $display("FAIL rsthit_act got %b exp 0", act0); end
    checks++; if (ox0 !== 10'd200) begin errors++; $display("FAIL rsthit_x got %0d exp 200", ox0); end
    checks++; if (oy0 !== 10'd100) begin errors++; $display("FAIL rsthit_y got %0d exp 100", oy0); end
    px0 = 10'd500; py0 = 10'd400;
    @(negedge clk);
    rst0 = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (act0 !== 1'b0) begin errors++; $display("FAIL idle_wait_act got %b exp 0", act0); end
    checks++; if (oy0 !== 10'd100) begin errors++; $display("FAIL idle_wait_y got %0d exp 100", oy0); end
    $display("reset_mid_hit: back in idle at x=%0d y=%0d", ox0, oy0);
  endtask

  task automatic test_y_wrap;
    int exp_x;
`ifdef FOLLOWER_RESPAWN_EN
    exp_x = 300;
`else
    exp_x = 312;
`endif
    mf1 = 1'b1;
    @(negedge clk);
    checks++; if (oy1 !== 10'd0) begin errors++; $display("FAIL ywrap_first got %0d exp 0", oy1); end
    checks++; if (act1 !== 1'b1) begin errors++; $display("FAIL ywrap_active got %b exp 1", act1); end
    checks++; if (ox1 !== 10'd300) begin errors++; $display("FAIL ywrap_x0 got %0d exp 300", ox1); end
    repeat (239) @(negedge clk);
    checks++; if (oy1 !== 10'd478) begin errors++; $display("FAIL ywrap_y478 got %0d exp 478", oy1); end
    checks++; if (ox1 !== 10'd311) begin errors++; $display("FAIL ywrap_x311 got %0d exp 311", ox1); end
    @(negedge clk);
    mf1 = 1'b0;
    checks++; if (oy1 !== 10'd0) begin errors++; $display("FAIL ywrap_second got %0d exp 0", oy1); end
    checks++; if (ox1 !== 10'(exp_x)) begin errors++; $display("FAIL ywrap_respawn_x got %0d exp %0d", ox1, exp_x); end
    $display("y_wrap: y=%0d x=%0d", oy1, ox1);
  endtask

  task automatic test_x_wrap;
    mf2 = 1'b1; mf3 = 1'b1;
    @(negedge clk);
    mf2 = 1'b0; mf3 = 1'b0;
    checks++; if (act2 !== 1'b1) begin errors++; $display("FAIL xwrap_act2 got %b exp 1", act2); end
    repeat (4) @(negedge clk);
    checks++; if (ox2 !== 10'd639) begin errors++; $display("FAIL xwrap_r4 got %0d exp 639", ox2); end
    checks++; if (ox3 !== 10'd0) begin errors++; $display("FAIL xwrap_l4 got %0d exp 0", ox3); end
    repeat (4) @(negedge clk);
    checks++; if (ox2 !== 10'd0) begin errors++; $display("FAIL xwrap_r8 got %0d exp 0", ox2); end
    checks++; if (ox3 !== 10'd639) begin errors++; $display("FAIL xwrap_l8 got %0d exp 639", ox3); end
    $display("x_wrap: right=%0d left=%0d", ox2, ox3);
  endtask

  // Reference model: mode 0 idle, 1 running, 2 hit; phase counts RUN cycles modulo CAR_DIV.
  task automatic test_random;
    int mode, mx, my, phase, hit_cycles, px, py, hits_seen;
    bit strobe, wrap;
    @(negedge clk);
    rst2 = 1'b1; mf2 = 1'b0; px2 = 10'd300; py2 = 10'd200;
    #1 rst2 = 1'b0;
    mode = 0; mx = U2_X; my = U2_Y; phase = 0; hit_cycles = 0; hits_seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      checks++; if (ox2 !== 10'(mx)) begin errors++; $display("FAIL rand_x i=%0d got %0d exp %0d", i, ox2, mx); end
      checks++; if (oy2 !== 10'(my)) begin errors++; $display("FAIL rand_y i=%0d got %0d exp %0d", i, oy2, my); end
      checks++; if (hit2 !== (mode == 2)) begin errors++; $display("FAIL rand_hit i=%0d got %b exp %b", i, hit2, mode == 2); end
      checks++; if (act2 !== (mode == 1)) begin errors++; $display("FAIL rand_act i=%0d got %b exp %b", i, act2, mode == 1); end
      if (mode == 2) begin
        hit_cycles++;
        if (hit_cycles >= 4) begin
          rst2 = 1'b1;
          #1;
          mode = 0; mx = U2_X; my = U2_Y; phase = 0; hit_cycles = 0; hits_seen++;
          checks++; if (ox2 !== 10'(mx) || oy2 !== 10'(my) || hit2 !== 1'b0 || act2 !== 1'b0) begin
            errors++; $display("FAIL rand_reset got x=%0d y=%0d h=%b a=%b exp x=%0d y=%0d h=0 a=0", ox2, oy2, hit2, act2, mx, my);
          end
          rst2 = 1'b0;
        end
      end
      strobe = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        px = mx + int'($urandom_range(0, 80)) - 40;
        py = my + int'($urandom_range(0, 40)) - 20;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
      end else begin
        px = int'($urandom_range(0, 639));
        py = int'($urandom_range(0, 479));
      end
      mf2 = strobe; px2 = 10'(px); py2 = 10'(py);
      if (mode == 1 && px < mx + 32 && mx < px + 16 && py < my + 16 && my < py + 16) begin
        mode = 2;
      end else if (mode == 1 || (mode == 0 && strobe)) begin
        if (mode == 1) begin
          if (phase == U2_DIV - 1) mx = (mx + 1) % 640;
          phase = (phase + 1) % U2_DIV;
        end else begin
          phase = 0;
        end
        mode = 1;
        if (strobe) begin
          wrap = (my + 2 >= 480);
          my = wrap ? 0 : my + 2;
`ifdef FOLLOWER_RESPAWN_EN
          if (wrap) begin mx = U2_X; phase = 0; end
`endif
        end
      end
    end
    $display("random: 2000 cycles, %0d hit/reset cycles", hits_seen);
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    mf0 = 1'b0; mf1 = 1'b0; mf2 = 1'b0; mf3 = 1'b0;
    px0 = 10'd500; py0 = 10'd400;
    px1 = 10'd0;   py1 = 10'd0;
    px2 = 10'd300; py2 = 10'd200;
    px3 = 10'd300; py3 = 10'd200;
    test_reset();
    test_scroll();
    test_collision();
    test_reset_mid_hit();
    test_y_wrap();
    test_x_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obstacle_follower.md
OBSTACLE_FOLLOWER -- requirements
Module: obstacle_follower

Interface
REQ-001 Parameter Y_INIT, default 0: obstacle y at reset, 0..479.
REQ-002 Parameter X_INIT, default 0: obstacle x at reset and respawn, 0..639.
REQ-003 Parameter CAR_DIV, default 50000: clk cycles per 1-pixel horizontal step, at least 2.
REQ-004 Parameter DIR, default 0: 0 = moves right (+x), 1 = moves left (-x).
REQ-005 Parameter OBS_W, default 32; parameter OBS_H, default 16: obstacle box size in pixels.
REQ-006 clk  input  1  single system clock; all state changes on posedge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 move_followers  input  1  one-cycle strobe from the vertical scroller; scroll down one step.
REQ-009 player_x  input  10  player box left edge, pixels.
REQ-010 player_y  input  10  player box top edge, pixels.
REQ-011 obs_x  output  10  obstacle left edge, registered.
REQ-012 obs_y  output  10  obstacle top edge, registered.
REQ-013 hit  output  1  latched collision flag, registered.
REQ-014 active  output  1  high in RUN state.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and HIT.
REQ-016 Transitions: IDLE->RUN on the first move_followers strobe; RUN->HIT on collision; HIT exits only on reset.
REQ-017 In IDLE, obs_x, obs_y and the step counter SHALL hold; the strobe that causes IDLE->RUN SHALL also apply its y step.
REQ-018 Each move_followers strobe in IDLE or RUN SHALL update obs_y: 0 if obs_y+2 >= 480, else obs_y+2. Use 11-bit sum, no overflow.
REQ-019 In RUN, step counter SHALL count 0..CAR_DIV-1; on CAR_DIV-1 it returns to 0 and obs_x steps once.
REQ-020 Step counter SHALL be 0 on RUN entry.
REQ-021 x step for DIR=0: 639 -> 0, else +1. x step for DIR=1: 0 -> 639, else -1.
REQ-022 A y step and an x step in the same cycle SHALL both apply in that cycle.
REQ-023 Collision SHALL be evaluated every RUN cycle on the registered obs_x, obs_y and the current player inputs, using 11-bit arithmetic.
REQ-024 The collision condition SHALL be: player_x < obs_x+OBS_W, and obs_x < player_x+16, and player_y < obs_y+OBS_H, and obs_y < player_y+16.
REQ-025 On collision, hit SHALL rise on the next posedge, coincident with HIT entry; no motion SHALL occur in that cycle.
REQ-026 In HIT, obs_x and obs_y SHALL freeze, hit=1, active=0, and strobes SHALL be ignored.
REQ-027 Collision SHALL NOT be evaluated in IDLE or HIT.
REQ-028 Latency: every output changes exactly one posedge after its cause; there are no combinational outputs.

Reset
REQ-029 Asserting reset at any time, including mid-HIT, SHALL asynchronously force IDLE, obs_x=X_INIT, obs_y=Y_INIT, hit=0, active=0 and step counter=0.
REQ-030 After reset deasserts, the block SHALL wait in IDLE for a strobe.

Configuration
REQ-031 Macro FOLLOWER_RESPAWN_EN SHALL control respawn on y wrap.
REQ-032 With FOLLOWER_RESPAWN_EN defined: a y wrap to 0 SHALL also load obs_x=X_INIT and clear the step counter, overriding any x step in that cycle.
REQ-033 Without FOLLOWER_RESPAWN_EN: a y wrap SHALL leave obs_x and the step counter unaffected.

Verification
REQ-034 Reset check: Y_INIT=100, X_INIT=200; assert reset -> obs_x=200, obs_y=100, hit=0, active=0, with no clock edge needed.
REQ-035 Scroll step: three strobes from IDLE -> obs_y=106, active=1 after the first strobe, and no x change before CAR_DIV cycles.
REQ-036 Scroll wrap: Y_INIT=478, one strobe -> obs_y=0. With FOLLOWER_RESPAWN_EN, obs_x reloads to X_INIT.
REQ-037 Horizontal wrap: CAR_DIV=4, DIR=0, X_INIT=638, player far away; 8 clocks in RUN -> obs_x=0. Same setup with DIR=1, X_INIT=1 -> obs_x=639.
REQ-038 Collision: in RUN, player at (obs_x+OBS_W-1, obs_y) -> hit=1 next edge, then positions frozen under further strobes. Player at (obs_x+OBS_W, obs_y) -> no hit.
REQ-039 Reset mid-HIT: assert reset while hit=1 -> IDLE, hit=0, positions back at X_INIT/Y_INIT.
